// File: rtl/tlcd_text_writer.sv
// tlcd_text_writer
// Sends the LCD init command set once the custom-font loader is done, then
// draws a 2x16 character buffer. An UPDATE pulse requests a redraw; pulses
// arriving while busy are merged into one pending redraw.
// Every LCD write is a 3-cycle SETUP / STROBE / HOLD transaction.
// Optional build macro: TLCD_CURSOR_BLINK_EN (blinking cursor placed at the
// last written buffer position after every redraw).
module tlcd_text_writer #(
    parameter int CLEAR_WAIT = 16,
    parameter int LINE_LEN   = 16
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       FONT_DONE,
    input  logic       WR_EN,
    input  logic [4:0] WR_ADDR,
    input  logic [7:0] WR_DATA,
    input  logic       UPDATE,
    output logic       TLCD_E,
    output logic       TLCD_RS,
    output logic       TLCD_RW,
    output logic [7:0] TLCD_DATA,
    output logic       BUSY,
    output logic [2:0] STATE
);

    localparam logic [2:0] S_WAIT_FONT = 3'd0;
    localparam logic [2:0] S_INIT      = 3'd1;
    localparam logic [2:0] S_L1_ADDR   = 3'd2;
    localparam logic [2:0] S_L1_DATA   = 3'd3;
    localparam logic [2:0] S_L2_ADDR   = 3'd4;
    localparam logic [2:0] S_L2_DATA   = 3'd5;
    localparam logic [2:0] S_IDLE      = 3'd6;

    localparam logic [1:0] PH_SETUP  = 2'd0;
    localparam logic [1:0] PH_STROBE = 2'd1;

    localparam logic [4:0] LAST_IDX   = 5'(LINE_LEN - 1);
    localparam logic [7:0] CLEAR_CNT  = 8'(CLEAR_WAIT);
`ifdef TLCD_CURSOR_BLINK_EN
    localparam logic [7:0] CMD_DISP_ON = 8'h0F;
`else
    localparam logic [7:0] CMD_DISP_ON = 8'h0C;
`endif

    logic [2:0] r_state;
    logic [1:0] r_ph;
    logic [4:0] r_idx;
    logic [7:0] r_wait;
    logic       r_pend;
    logic       r_e;
    logic       r_rs;
    logic [7:0] r_data;
    logic [7:0] r_buf [2*LINE_LEN];
`ifdef TLCD_CURSOR_BLINK_EN
    logic [6:0] r_cursor;
`endif

    logic [4:0] w_next_idx;
    logic [7:0] w_init_cmd;

    // Next transaction index and the init command that goes with it
    always_comb begin
        w_next_idx = r_idx + 5'd1;
        case (w_next_idx[1:0])
            2'd0:    w_init_cmd = 8'h38;
            2'd1:    w_init_cmd = CMD_DISP_ON;
            2'd2:    w_init_cmd = 8'h06;
            2'd3:    w_init_cmd = 8'h01;
            default: w_init_cmd = 8'h38;
        endcase
    end

    // Buffer writes, pending-update flag, sequencer and registered bus outputs
    always_ff @(posedge CLK or posedge RESETN) begin
        if (RESETN) begin
            r_state <= S_WAIT_FONT;
            r_ph    <= PH_SETUP;
            r_idx   <= 5'd0;
            r_wait  <= 8'd0;
            r_pend  <= 1'b0;
            r_e     <= 1'b0;
            r_rs    <= 1'b0;
            r_data  <= 8'h00;
            for (int i = 0; i < 2*LINE_LEN; i++) begin
                r_buf[i] <= 8'h20;
            end
`ifdef TLCD_CURSOR_BLINK_EN
            r_cursor <= 7'd0;
`endif
        end else begin
            // Reads below see the pre-write value, so a same-cycle hit sends old data.
            if (WR_EN) begin
                r_buf[WR_ADDR] <= WR_DATA;
`ifdef TLCD_CURSOR_BLINK_EN
                r_cursor <= WR_ADDR[4] ? {3'b100, WR_ADDR[3:0]} : {3'b000, WR_ADDR[3:0]};
`endif
            end
            if (UPDATE && (r_state != S_IDLE)) begin
                r_pend <= 1'b1;
            end
            case (r_state)
                S_WAIT_FONT: begin
                    if (FONT_DONE) begin
                        r_state <= S_INIT;
                        r_idx   <= 5'd0;
                        r_ph    <= PH_SETUP;
                        r_rs    <= 1'b0;
                        r_data  <= 8'h38;
                    end
                end
                S_IDLE: begin
                    if (UPDATE || r_pend) begin
                        r_pend  <= 1'b0;
                        r_state <= S_L1_ADDR;
                        r_ph    <= PH_SETUP;
                        r_rs    <= 1'b0;
                        r_data  <= 8'h80;
                    end
                end
                default: begin
                    if (r_wait != 8'd0) begin
                        // Post-clear settle time: bus idle with E low
                        r_wait <= r_wait - 8'd1;
                        if (r_wait == 8'd1) begin
                            r_state <= S_L1_ADDR;
                            r_ph    <= PH_SETUP;
                            r_rs    <= 1'b0;
                            r_data  <= 8'h80;
                        end
                    end else if (r_ph == PH_SETUP) begin
                        r_ph <= PH_STROBE;
                        r_e  <= 1'b1;
                    end else if (r_ph == PH_STROBE) begin
                        r_ph <= 2'd2;
                        r_e  <= 1'b0;
                    end else begin
                        // End of HOLD: RS/DATA for the next transaction change only here
                        r_ph <= PH_SETUP;
                        case (r_state)
                            S_INIT: begin
                                if (r_idx < 5'd3) begin
                                    r_idx  <= w_next_idx;
                                    r_data <= w_init_cmd;
                                end else if (CLEAR_CNT != 8'd0) begin
                                    r_wait <= CLEAR_CNT;
                                end else begin
                                    r_state <= S_L1_ADDR;
                                    r_data  <= 8'h80;
                                end
                            end
                            S_L1_ADDR: begin
                                r_state <= S_L1_DATA;
                                r_idx   <= 5'd0;
                                r_rs    <= 1'b1;
                                r_data  <= r_buf[5'd0];
                            end
                            S_L1_DATA: begin
                                if (r_idx < LAST_IDX) begin
                                    r_idx  <= w_next_idx;
                                    r_data <= r_buf[{1'b0, w_next_idx[3:0]}];
                                end else begin
                                    r_state <= S_L2_ADDR;
                                    r_rs    <= 1'b0;
                                    r_data  <= 8'hC0;
                                end
                            end
                            S_L2_ADDR: begin
                                r_state <= S_L2_DATA;
                                r_idx   <= 5'd0;
                                r_rs    <= 1'b1;
                                r_data  <= r_buf[5'd16];
                            end
                            S_L2_DATA: begin
                                if (r_idx < LAST_IDX) begin
                                    r_idx  <= w_next_idx;
                                    r_data <= r_buf[{1'b1, w_next_idx[3:0]}];
                                end else if (r_idx == LAST_IDX) begin
`ifdef TLCD_CURSOR_BLINK_EN
                                    // Extra set-DDRAM-address command parks the cursor
                                    r_idx  <= w_next_idx;
                                    r_rs   <= 1'b0;
                                    r_data <= 8'h80 | {1'b0, r_cursor};
`else
                                    r_state <= S_IDLE;
`endif
                                end else begin
                                    r_state <= S_IDLE;
                                end
                            end
                            default: begin
                                r_state <= S_IDLE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign TLCD_E    = r_e;
    assign TLCD_RS   = r_rs;
    assign TLCD_RW   = 1'b0;
    assign TLCD_DATA = r_data;
    assign BUSY      = (r_state != S_IDLE);
    assign STATE     = r_state;

endmodule

// File: tb/tb_tlcd_text_writer.sv
// Self-checking bench for tlcd_text_writer: expected LCD transactions are
// queued as stimulus is driven and compared on every E strobe.
module tb_tlcd_text_writer;

`ifdef TLCD_CURSOR_BLINK_EN
    localparam int  TX  = 35;
    localparam bit  CUR = 1'b1;
    localparam logic [7:0] DISP = 8'h0F;
`else
    localparam int  TX  = 34;
    localparam bit  CUR = 1'b0;
    localparam logic [7:0] DISP = 8'h0C;
`endif

    logic       CLK = 1'b0;
    logic       rst = 1'b0;
    logic       FONT_DONE = 1'b0;
    logic       WR_EN = 1'b0;
    logic [4:0] WR_ADDR = 5'd0;
    logic [7:0] WR_DATA = 8'h00;
    logic       UPDATE = 1'b0;
    logic       TLCD_E, TLCD_RS, TLCD_RW, BUSY;
    logic [7:0] TLCD_DATA;
    logic [2:0] STATE;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int strobes = 0;
    logic [8:0] exp_q [$];
    logic [7:0] mbuf [32];
    logic [7:0] mcur = 8'h00;

    logic       m_prev_e = 1'b0;
    logic [8:0] m_hold = 9'h000;
    logic [8:0] m_last = 9'h000;
    int         m_last_cyc = 0;
    logic [8:0] m_exp;

    tlcd_text_writer dut (
        .CLK(CLK), .RESETN(rst), .FONT_DONE(FONT_DONE),
        .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .UPDATE(UPDATE),
        .TLCD_E(TLCD_E), .TLCD_RS(TLCD_RS), .TLCD_RW(TLCD_RW),
        .TLCD_DATA(TLCD_DATA), .BUSY(BUSY), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Strobe monitor: every E rise pops one expected {RS,DATA}
    always @(negedge CLK) begin
        if (TLCD_E && !m_prev_e) begin
            strobes++;
            chk("rw_low", {31'd0, TLCD_RW}, 32'd0);
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_strobe observed=%0h expected=none", {TLCD_RS, TLCD_DATA});
            end
            if (exp_q.size() != 0) begin
                m_exp = exp_q.pop_front();
                chk("strobe", {23'd0, TLCD_RS, TLCD_DATA}, {23'd0, m_exp});
                if (m_exp == 9'h080 && m_last == 9'h001)
                    chk("clear_gap", cyc - m_last_cyc, 32'd19);
                m_last = m_exp;
                m_last_cyc = cyc;
            end
            m_hold = {TLCD_RS, TLCD_DATA};
        end else if (!TLCD_E && m_prev_e && !rst) begin
            chk("hold", {23'd0, TLCD_RS, TLCD_DATA}, {23'd0, m_hold});
        end
        m_prev_e = TLCD_E;
    end

    task automatic push_init();
        exp_q.push_back(9'h038);
        exp_q.push_back({1'b0, DISP});
        exp_q.push_back(9'h006);
        exp_q.push_back(9'h001);
    endtask

    task automatic push_redraw();
        exp_q.push_back(9'h080);
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, mbuf[i]});
        exp_q.push_back(9'h0C0);
        for (int i = 16; i < 32; i++) exp_q.push_back({1'b1, mbuf[i]});
        if (CUR) exp_q.push_back({1'b0, 8'h80 | mcur});
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        @(negedge CLK);
        WR_EN = 1'b1; WR_ADDR = a; WR_DATA = d;
        @(negedge CLK);
        WR_EN = 1'b0;
        mbuf[a] = d;
        mcur = a[4] ? {4'h4, a[3:0]} : {4'h0, a[3:0]};
    endtask

    task automatic pulse_update();
        @(negedge CLK); UPDATE = 1'b1;
        @(negedge CLK); UPDATE = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (BUSY !== 1'b0 && n < 400) begin
            @(posedge CLK); #1; n++;
        end
    endtask

    initial begin
        int n;
        for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;

        // Reset state
        #2 rst = 1'b1;
        #1;
        chk("rst_state", {29'd0, STATE}, 32'd0);
        chk("rst_e", {31'd0, TLCD_E}, 32'd0);
        chk("rst_bus", {23'd0, TLCD_RS, TLCD_DATA}, 32'd0);
        chk("rst_busy", {31'd0, BUSY}, 32'd1);
        repeat (2) @(negedge CLK);
        rst = 1'b0;

        // FONT_DONE low for 500 cycles: nothing happens
        repeat (500) @(posedge CLK);
        #1;
        chk("nofont_strobes", strobes, 32'd0);
        chk("nofont_busy", {31'd0, BUSY}, 32'd1);
        chk("nofont_state", {29'd0, STATE}, 32'd0);

        // Init plus first redraw of spaces
        push_init();
        push_redraw();
        @(negedge CLK); FONT_DONE = 1'b1;
        @(posedge CLK); #1;
        chk("init_state", {29'd0, STATE}, 32'd1);
        wait_idle(n);
        chk("init_latency", n, 12 + 16 + 3*TX);
        chk("idle_state", {29'd0, STATE}, 32'd6);

        // Writes in IDLE then a redraw
        wr(5'd0, 8'h00);
        wr(5'd17, 8'h41);
        push_redraw();
        pulse_update();
        wait_idle(n);
        chk("redraw_latency", n, 3*TX);

        // Three UPDATEs during a redraw merge into one extra pass
        push_redraw();
        push_redraw();
        pulse_update();
        repeat (10) @(negedge CLK);
        pulse_update();
        pulse_update();
        pulse_update();
        wait_idle(n);
        chk("merge_first_idle", {29'd0, STATE}, 32'd6);
        @(posedge CLK); #1;
        chk("merge_one_idle_cycle", {29'd0, STATE}, 32'd2);
        wait_idle(n);
        chk("merge_second_pass", n, 3*TX);
        repeat (20) @(posedge CLK);
        #1;
        chk("merge_no_third", {29'd0, STATE}, 32'd6);
        chk("merge_queue", exp_q.size(), 32'd0);

        // Write buf[15] during L1_DATA before index 15 goes out
        mbuf[15] = 8'h5A;
        mcur = 8'h0F;
        push_redraw();
        pulse_update();
        n = 0;
        while (STATE !== 3'd3 && n < 50) begin @(posedge CLK); #1; n++; end
        chk("reach_l1_data", {29'd0, STATE}, 32'd3);
        wr(5'd15, 8'h5A);
        wait_idle(n);
        chk("midwrite_idle", {31'd0, BUSY}, 32'd0);

        // Reset during a STROBE cycle
        push_redraw();
        pulse_update();
        n = 0;
        do begin @(negedge CLK); n++; end
        while (!(TLCD_E === 1'b1 && STATE === 3'd3) && n < 200);
        #1 rst = 1'b1;
        #1;
        chk("abort_e", {31'd0, TLCD_E}, 32'd0);
        chk("abort_state", {29'd0, STATE}, 32'd0);
        chk("abort_busy", {31'd0, BUSY}, 32'd1);
        chk("abort_bus", {23'd0, TLCD_RS, TLCD_DATA}, 32'd0);
        repeat (2) @(negedge CLK);
        exp_q.delete();
        for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
        mcur = 8'h00;
        push_init();
        push_redraw();
        rst = 1'b0;
        @(posedge CLK); #1;
        chk("restart_state", {29'd0, STATE}, 32'd1);
        wait_idle(n);
        chk("restart_latency", n, 12 + 16 + 3*TX);

        chk("final_queue", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tlcd_text_writer.md
Name: tlcd_text_writer

Overview:
Downstream stage of the custom-font loader on the text-LCD path. Once the font loader reports completion, this block sends the LCD display-init commands and then draws a 32-character screen buffer (2 lines x 16) from internal storage onto the LCD. Writers fill the buffer through a simple write port; an UPDATE pulse redraws the screen. Codes 0x00-0x04 in the buffer display the CGRAM glyphs loaded by the font loader. An external mux hands the TLCD bus to this block once FONT_DONE is high.

Parameters:
CLEAR_WAIT, 16, idle cycles inserted after the Clear Display command, with E=0
LINE_LEN, 16, characters per line; fixed at 16, and the buffer holds 2*LINE_LEN entries

Ports:
CLK  in  1  system clock; all state changes on the rising edge
RESETN  in  1  asynchronous, active-high reset; the name is kept as used in the codebase
FONT_DONE  in  1  level input; high when the font loader has finished
WR_EN  in  1  buffer write strobe
WR_ADDR  in  5  buffer index; 0-15 is line 1, 16-31 is line 2
WR_DATA  in  8  character code
UPDATE  in  1  one-cycle redraw request
TLCD_E  out  1  LCD enable strobe, generated internally
TLCD_RS  out  1  0 = command, 1 = data
TLCD_RW  out  1  always 0 (write only)
TLCD_DATA  out  8  LCD data bus
BUSY  out  1  high unless in IDLE
STATE  out  3  current state encoding

Behaviour:
- Reset (asynchronous, while RESETN=1):
  - STATE=WAIT_FONT.
  - TLCD_E=0, TLCD_RS=0, TLCD_RW=0, TLCD_DATA=0x00, BUSY=1.
  - All 32 buffer entries = 0x20 (space); pending-update flag cleared; all counters 0.
  - A reset in the middle of any operation aborts it immediately, including during the E-high phase; E drops to 0 asynchronously.
- LCD transaction: every LCD write takes exactly 3 cycles.
  - SETUP: E=0; RS and DATA are driven.
  - STROBE: E=1; RS and DATA held.
  - HOLD: E=0; RS and DATA held.
  - RS and DATA change only in SETUP.
- State encodings: WAIT_FONT=0, INIT=1, L1_ADDR=2, L1_DATA=3, L2_ADDR=4, L2_DATA=5, IDLE=6.
- WAIT_FONT: bus outputs stay at their reset values. Leave for INIT on the first rising edge at which FONT_DONE=1.
- INIT: send four commands in order, each with RS=0.
  - 0x38: function set, 8-bit, 2 lines.
  - 0x0C: display on, cursor off.
  - 0x06: entry mode, increment.
  - 0x01: clear display. This transaction is followed by CLEAR_WAIT cycles with E=0.
  - Then go to L1_ADDR.
- L1_ADDR: one command with RS=0, DATA=0x80.
- L1_DATA: 16 data transactions with RS=1, DATA=buf[0..15] in order.
- L2_ADDR: one command with RS=0, DATA=0xC0.
- L2_DATA: 16 data transactions with RS=1, DATA=buf[16..31] in order.
- After L2_DATA, go to IDLE (BUSY=0). One redraw = 34 transactions = 102 cycles.
- Buffer reads: each entry is sampled in the SETUP cycle of its own transaction. A write to an entry that has not been sent yet appears in the current redraw.
- Buffer writes: WR_EN writes buf[WR_ADDR]<=WR_DATA at any time, in any state. If a write and a read hit the same entry in the same cycle, the old value is sent.
- UPDATE:
  - In IDLE: the next cycle is L1_ADDR SETUP.
  - In WAIT_FONT, INIT, or any drawing state: sets the pending flag. When the current pass reaches IDLE with the flag set, the flag is cleared and the block goes straight to L1_ADDR, spending one cycle in IDLE.
  - Several UPDATE pulses before the flag is serviced merge into one redraw.
- FONT_DONE falling after INIT has started has no effect. Only a reset returns the block to WAIT_FONT.

Optional Feature:
TLCD_CURSOR_BLINK_EN
- Defined: the display-on command is 0x0F (cursor on, blink on). After every redraw, one more command is sent, 0x80 | cursor position. The cursor position is the last WR_ADDR written, mapped to 0x00-0x0F for line 1 and 0x40-0x4F for line 2. A redraw is then 35 transactions.
- Not defined: the display-on command is 0x0C and a redraw is 34 transactions.

Test Plan:
- Reset then FONT_DONE=1 -> E pulses carry 0x38, 0x0C, 0x06, 0x01 (RS=0); a gap of 16 cycles with E=0 after 0x01; then 0x80 and 32 data bytes of 0x20 with RS=1; BUSY falls 12+16+102 cycles after FONT_DONE is sampled.
- In IDLE, write buf[0]=0x00, buf[17]=0x41, then pulse UPDATE -> buf[0] is sent as 0x00 right after 0x80; byte 2 after 0xC0 is 0x41; 102 cycles later BUSY=0.
- UPDATE pulsed three times during a redraw -> exactly one further redraw follows, and exactly one IDLE cycle sits between the two passes.
- During L1_DATA, write buf[15]=0x5A before index 15 is sent -> 0x5A appears on the bus.
- RESETN asserted during a STROBE cycle -> TLCD_E=0 at once; STATE=0; the buffer reads back as 0x20; a new FONT_DONE restarts the init sequence.
- FONT_DONE held at 0 for 500 cycles -> no E pulses, BUSY=1, STATE=0.
